raisin64_mem_arbiter: RTL and testbench
=======================================

// Module: raisin64_mem_arbiter
// PURPOSE
//  Shares one memory port between the raisin64 instruction-fetch and data load/store requesters.
//  Sits between the CPU core and the unified memory, replacing separate imem/dmem ports.
//  Grants one requester at a time, forwards address, data and strobes, and routes the
//  response back to the granted requester. Alternates grants when both requesters contend.
// PARAMETERS
//  ADDR_W   64   address width, byte address
//  DATA_W   64   data width; byte-enable width is DATA_W/8
//  TIMEOUT  255  cycles to wait for m_ack before abort; used only with MEM_ARB_TIMEOUT_EN
// PORTS
//  clk       in   1         system clock, all state on rising edge
//  rst_n     in   1         asynchronous active-low reset
//  i_req     in   1         fetch request, held until i_ack
//  i_addr    in   ADDR_W    fetch address
//  i_ack     out  1         fetch done, 1-cycle pulse
//  i_rdata   out  DATA_W    fetch data, valid with i_ack
//  d_req     in   1         data request, held until d_ack
//  d_we      in   1         1 = store, 0 = load
//  d_addr    in   ADDR_W    data address
//  d_wdata   in   DATA_W    store data
//  d_be      in   DATA_W/8  store byte enables
//  d_ack     out  1         data done, 1-cycle pulse
//  d_rdata   out  DATA_W    load data, valid with d_ack
//  m_req     out  1         memory request, held until m_ack
//  m_we      out  1         memory write enable
//  m_addr    out  ADDR_W    memory address
//  m_wdata   out  DATA_W    memory write data
//  m_be      out  DATA_W/8  memory byte enables
//  m_ack     in   1         memory done, 1-cycle pulse
//  m_rdata   in   DATA_W    memory read data, valid with m_ack
//  err       out  1         sticky timeout flag; tied 0 without MEM_ARB_TIMEOUT_EN
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; last_grant=D, so the first contended grant goes to fetch.
//  - Async reset mid-transaction drops m_req at once; the pending transaction is lost.
//  - All outputs are registered. The m_* signals are latched from the winner on grant and held stable until m_ack.
//  - FSM states: IDLE -> GNT_I | GNT_D -> RESP -> IDLE.
//  - IDLE, winner selection:
//      only one req high: that requester wins.
//      both high: the requester not equal to last_grant wins.
//      neither high: stay in IDLE.
//    On a win: go to GNT_x, assert m_req next cycle, update last_grant.
//  - GNT_x: hold m_req=1. On m_ack: go to RESP, capture m_rdata into x_rdata, pulse x_ack, drop m_req.
//  - For fetch grants, m_we=0 and m_be=all-ones.
//  - RESP: no m_req. Requesters drop req in this cycle. Go to IDLE. Back-to-back grants are therefore
//    spaced by at least 3 cycles: req sampled -> m_req -> m_ack -> RESP -> IDLE.
//  - Latency: req high in IDLE at cycle N -> m_req=1 at N+1; m_ack at cycle M -> x_ack=1 at M+1.
//  - m_ack outside GNT_x is ignored. x_rdata holds its value until the next ack to that requester.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//    - 8-bit+ counter clears on grant and increments each GNT_x cycle with m_ack low.
//    - At count==TIMEOUT: drop m_req, go to RESP, pulse x_ack with x_rdata=0, set err=1.
//    - err stays set until reset.
//  MEM_ARB_TIMEOUT_EN undefined: no counter; GNT_x waits indefinitely; err=0.
// TESTING
//  - Single fetch: i_req, i_addr=0x100; m_ack with m_rdata=0xDEAD at 2 cycles after grant
//    -> m_addr=0x100, m_we=0, i_ack one cycle later with i_rdata=0xDEAD; d_ack stays 0.
//  - Single store: d_req, d_we=1, d_addr=0x2000, d_wdata=0x55AA, d_be=0x0F
//    -> m_* match the inputs exactly; d_ack pulses once.
//  - Contention from reset: i_req and d_req together -> fetch granted first, then data.
//    Holding both high afterwards gives strict alternation I,D,I,D.
//  - Reset mid-transaction: rst_n low while m_req=1 -> m_req, acks and err go 0 immediately;
//    a fresh request after reset is served normally.
//  - With MEM_ARB_TIMEOUT_EN and TIMEOUT=4, m_ack never driven -> m_req drops after 4 cycles;
//    i_ack pulses with i_rdata=0; err=1 and stays 1.
//  - Stray m_ack while IDLE -> no ack to either requester, no state change.

Source files
------------

// File: rtl/raisin64_mem_arbiter.sv
// ---------------------------------------------------------------------------
// raisin64_mem_arbiter
//
// Shares one memory port between the raisin64 instruction-fetch requester
// (i_*) and the data load/store requester (d_*). One requester is granted at a
// time. Its address, data and strobes are latched onto the m_* port, and the
// memory response is routed back to it. When both requesters contend, grants
// alternate, starting with fetch after reset.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   When defined, a watchdog aborts a grant that sees no m_ack within TIMEOUT
//   cycles. The abort acks the requester with zero data and sets the sticky
//   err flag. When undefined, a grant waits for m_ack indefinitely and err
//   reads 0.
//
// Parameters
//   ADDR_W   byte-address width
//   DATA_W   data width (byte enables are DATA_W/8 wide)
//   TIMEOUT  watchdog limit in grant cycles (MEM_ARB_TIMEOUT_EN only)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_req/i_addr          fetch request, held until i_ack
//   i_ack/i_rdata         fetch done pulse and read data
//   d_req/d_we/d_addr     data request (d_we=1 store), held until d_ack
//   d_wdata/d_be          store data and byte enables
//   d_ack/d_rdata         data done pulse and load data
//   m_req/m_we/m_addr     memory request, held until m_ack
//   m_wdata/m_be          memory write data and byte enables
//   m_ack/m_rdata         memory done pulse and read data
//   err                   sticky watchdog flag
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no grant; choose a winner from i_req/d_req
// GNT_I   | fetch owns the memory port, m_req held until m_ack
// GNT_D   | data owns the memory port, m_req held until m_ack
// RESP    | ack pulse to the owner; requests ignored for this cycle
// ---------------------------------------------------------------------------
module raisin64_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                err
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // 1 when the data requester received the most recent grant
  logic r_last_d;

  logic w_win_i;
  logic w_win_d;
  logic w_timeout;

  logic              w_m_req_nxt;
  logic              w_m_we_nxt;
  logic [ADDR_W-1:0] w_m_addr_nxt;
  logic [DATA_W-1:0] w_m_wdata_nxt;
  logic [BE_W-1:0]   w_m_be_nxt;
  logic              w_i_ack_nxt;
  logic [DATA_W-1:0] w_i_rdata_nxt;
  logic              w_d_ack_nxt;
  logic [DATA_W-1:0] w_d_rdata_nxt;
  logic              w_err_nxt;
  logic              w_last_d_nxt;

  // Fetch wins when it is the only requester, or when both contend and data
  // had the previous grant.
  assign w_win_i = i_req & (~d_req | r_last_d);
  assign w_win_d = d_req & ~w_win_i;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] r_cnt;
  logic             w_in_gnt;

  assign w_in_gnt = (r_state == S_GNT_I) || (r_state == S_GNT_D);

  // Abort in the cycle that would bring the count to TIMEOUT. m_req is then
  // high for exactly TIMEOUT cycles.
  assign w_timeout = w_in_gnt && !m_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

  // The count is cleared in IDLE, so every grant starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (w_in_gnt && !m_ack) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_win_i) begin
          w_state_nxt = S_GNT_I;
        end else if (w_win_d) begin
          w_state_nxt = S_GNT_D;
        end
      end
      S_GNT_I, S_GNT_D: begin
        if (m_ack || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: the next values of the registered outputs
  always_comb begin
    w_m_req_nxt   = m_req;
    w_m_we_nxt    = m_we;
    w_m_addr_nxt  = m_addr;
    w_m_wdata_nxt = m_wdata;
    w_m_be_nxt    = m_be;
    w_i_ack_nxt   = 1'b0;
    w_i_rdata_nxt = i_rdata;
    w_d_ack_nxt   = 1'b0;
    w_d_rdata_nxt = d_rdata;
    w_err_nxt     = err;
    w_last_d_nxt  = r_last_d;
    case (r_state)
      S_IDLE: begin
        if (w_win_i) begin
          w_m_req_nxt   = 1'b1;
          w_m_we_nxt    = 1'b0;
          w_m_addr_nxt  = i_addr;
          w_m_wdata_nxt = '0;
          w_m_be_nxt    = '1;
          w_last_d_nxt  = 1'b0;
        end else if (w_win_d) begin
          w_m_req_nxt   = 1'b1;
          w_m_we_nxt    = d_we;
          w_m_addr_nxt  = d_addr;
          w_m_wdata_nxt = d_wdata;
          w_m_be_nxt    = d_be;
          w_last_d_nxt  = 1'b1;
        end
      end
      S_GNT_I: begin
        if (m_ack) begin
          w_m_req_nxt   = 1'b0;
          w_i_ack_nxt   = 1'b1;
          w_i_rdata_nxt = m_rdata;
        end else if (w_timeout) begin
          w_m_req_nxt   = 1'b0;
          w_i_ack_nxt   = 1'b1;
          w_i_rdata_nxt = '0;
          w_err_nxt     = 1'b1;
        end
      end
      S_GNT_D: begin
        if (m_ack) begin
          w_m_req_nxt   = 1'b0;
          w_d_ack_nxt   = 1'b1;
          w_d_rdata_nxt = m_rdata;
        end else if (w_timeout) begin
          w_m_req_nxt   = 1'b0;
          w_d_ack_nxt   = 1'b1;
          w_d_rdata_nxt = '0;
          w_err_nxt     = 1'b1;
        end
      end
      S_RESP: begin
        w_m_req_nxt = 1'b0;
      end
      default: begin
        w_m_req_nxt = 1'b0;
      end
    endcase
  end

  // Output registers. Reset leaves last_grant on data, so fetch wins the first
  // contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
      i_ack    <= 1'b0;
      i_rdata  <= '0;
      d_ack    <= 1'b0;
      d_rdata  <= '0;
      err      <= 1'b0;
      r_last_d <= 1'b1;
    end else begin
      m_req    <= w_m_req_nxt;
      m_we     <= w_m_we_nxt;
      m_addr   <= w_m_addr_nxt;
      m_wdata  <= w_m_wdata_nxt;
      m_be     <= w_m_be_nxt;
      i_ack    <= w_i_ack_nxt;
      i_rdata  <= w_i_rdata_nxt;
      d_ack    <= w_d_ack_nxt;
      d_rdata  <= w_d_rdata_nxt;
      err      <= w_err_nxt;
      r_last_d <= w_last_d_nxt;
    end
  end

endmodule

// File: tb/tb_raisin64_mem_arbiter.sv
// Testbench for raisin64_mem_arbiter. Two requester processes and a memory
// responder drive the arbiter. A transaction-level model tracks the grants,
// and a scoreboard checks the returned data.
module tb_raisin64_mem_arbiter;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [63:0] i_addr;
  logic        i_ack;
  logic [63:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_be;
  logic        d_ack;
  logic [63:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_be;
  logic        m_ack;
  logic [63:0] m_rdata;
  logic        err;

  raisin64_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        tmo;
  } cmd_t;

  cmd_t        q_cmd_i[$];
  cmd_t        q_cmd_d[$];
  logic [63:0] q_exp_i[$];
  logic [63:0] q_exp_d[$];
  bit          glog[$];

  int n_cmp = 0;
  int n_mis = 0;

  bit busy_i = 0;
  bit busy_d = 0;
  int resp_mode = 0;   // 0 random delay, 1 fixed delay of 2, 2 never ack
  bit stray_en = 0;
  bit rand_gap = 0;

  // Memory contents as seen by the responder: a fixed function of the address
  function automatic logic [63:0] mem_f(input logic [63:0] a);
    return {a[31:0], ~a[63:32]} ^ 64'hDEAD_BEEF_0BAD_F00D;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Fetch requester
  initial begin
    cmd_t c;
    int   n;
    bit   done;
    bit   abort;
    i_req  = 1'b0;
    i_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && q_cmd_i.size() != 0) begin
        c = q_cmd_i.pop_front();
        busy_i = 1;
        i_addr = c.addr;
        i_req  = 1'b1;
        q_exp_i.push_back(c.tmo ? 64'h0 : mem_f(c.addr));
        n = 0; done = 0; abort = 0;
        while (!done && !abort) begin
          @(negedge clk);
          n++;
          if (!rst_n) abort = 1;
          else if (i_ack) done = 1;
          else if (n > 400) begin
            n_cmp++; n_mis++;
            $display("FAIL i_ack_wait: no i_ack after %0d cycles, required one", n);
            abort = 1;
          end
        end
        @(posedge clk); #1;
        i_req = 1'b0;
        if (rand_gap) repeat ($urandom_range(0, 2)) @(posedge clk);
        busy_i = 0;
      end
    end
  end

  // Data requester
  initial begin
    cmd_t c;
    int   n;
    bit   done;
    bit   abort;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_be    = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && q_cmd_d.size() != 0) begin
        c = q_cmd_d.pop_front();
        busy_d  = 1;
        d_we    = c.we;
        d_addr  = c.addr;
        d_wdata = c.wdata;
        d_be    = c.be;
        d_req   = 1'b1;
        q_exp_d.push_back(c.tmo ? 64'h0 : mem_f(c.addr));
        n = 0; done = 0; abort = 0;
        while (!done && !abort) begin
          @(negedge clk);
          n++;
          if (!rst_n) abort = 1;
          else if (d_ack) done = 1;
          else if (n > 400) begin
            n_cmp++; n_mis++;
            $display("FAIL d_ack_wait: no d_ack after %0d cycles, required one", n);
            abort = 1;
          end
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        if (rand_gap) repeat ($urandom_range(0, 2)) @(posedge clk);
        busy_d = 0;
      end
    end
  end

  // Memory responder: acks each m_req once after a delay; may send stray acks
  // while no request is pending.
  initial begin
    bit acked;
    int wcnt;
    m_ack   = 1'b0;
    m_rdata = '0;
    acked   = 0;
    wcnt    = 0;
    forever begin
      @(posedge clk); #1;
      m_ack = 1'b0;
      if (!rst_n) begin
        acked = 0;
        wcnt  = 0;
      end else if (m_req && !acked) begin
        if (resp_mode != 2) begin
          if (wcnt == 0) begin
            m_ack   = 1'b1;
            m_rdata = mem_f(m_addr);
            acked   = 1;
          end else begin
            wcnt--;
          end
        end
      end else if (!m_req) begin
        acked = 0;
        wcnt  = (resp_mode == 1) ? 2 : int'($urandom_range(0, 3));
        if (stray_en && $urandom_range(0, 5) == 0) begin
          m_ack   = 1'b1;
          m_rdata = {$urandom, $urandom};
        end
      end
    end
  end

  // Monitor: steps a transaction-level model once per clock from the inputs
  // seen in the previous cycle, then compares the DUT outputs against it.
  initial begin
    bit          mdl_busy, mdl_resp, mdl_own_d, mdl_last_d, mdl_err;
    int          mdl_wait;
    logic [63:0] mdl_rd_i, mdl_rd_d;
    logic        mdl_we;
    logic [63:0] mdl_addr, mdl_wdata;
    logic [7:0]  mdl_be;
    bit          p_rst, p_i_req, p_d_req, p_d_we, p_m_ack, p_mreq_obs;
    logic [63:0] p_i_addr, p_d_addr, p_d_wdata, p_m_rdata;
    logic [7:0]  p_d_be;
    logic [63:0] e;
    p_rst = 0; p_mreq_obs = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mdl_busy = 0; mdl_resp = 0; mdl_own_d = 0; mdl_last_d = 1; mdl_err = 0;
        mdl_wait = 0; mdl_rd_i = '0; mdl_rd_d = '0;
        q_exp_i.delete();
        q_exp_d.delete();
        p_mreq_obs = 0;
      end else begin
        if (p_rst) begin
          if (mdl_resp) begin
            mdl_resp = 0;
          end else if (mdl_busy) begin
            if (p_m_ack) begin
              mdl_busy = 0; mdl_resp = 1;
              if (mdl_own_d) mdl_rd_d = p_m_rdata; else mdl_rd_i = p_m_rdata;
            end else begin
              mdl_wait++;
`ifdef MEM_ARB_TIMEOUT_EN
              if (mdl_wait == TMO) begin
                mdl_busy = 0; mdl_resp = 1; mdl_err = 1;
                if (mdl_own_d) mdl_rd_d = '0; else mdl_rd_i = '0;
              end
`endif
            end
          end else if (p_i_req || p_d_req) begin
            mdl_own_d  = !(p_i_req && (!p_d_req || mdl_last_d));
            mdl_last_d = mdl_own_d;
            mdl_busy   = 1;
            mdl_wait   = 0;
            if (mdl_own_d) begin
              mdl_we = p_d_we; mdl_addr = p_d_addr; mdl_wdata = p_d_wdata; mdl_be = p_d_be;
            end else begin
              mdl_we = 1'b0; mdl_addr = p_i_addr; mdl_wdata = '0; mdl_be = 8'hFF;
            end
          end
        end
        chk("m_req", {63'd0, m_req}, {63'd0, mdl_busy});
        chk("i_ack", {63'd0, i_ack}, {63'd0, mdl_resp && !mdl_own_d});
        chk("d_ack", {63'd0, d_ack}, {63'd0, mdl_resp && mdl_own_d});
        chk("i_rdata_hold", i_rdata, mdl_rd_i);
        chk("d_rdata_hold", d_rdata, mdl_rd_d);
        chk("err", {63'd0, err}, {63'd0, mdl_err});
        if (mdl_busy) begin
          chk("m_addr", m_addr, mdl_addr);
          chk("m_we", {63'd0, m_we}, {63'd0, mdl_we});
          chk("m_be", {56'd0, m_be}, {56'd0, mdl_be});
          if (mdl_own_d) chk("m_wdata", m_wdata, mdl_wdata);
        end
        if (i_ack) begin
          if (q_exp_i.size() == 0) chk("i_ack_unexpected", 64'd1, 64'd0);
          else begin e = q_exp_i.pop_front(); chk("i_rdata_sb", i_rdata, e); end
        end
        if (d_ack) begin
          if (q_exp_d.size() == 0) chk("d_ack_unexpected", 64'd1, 64'd0);
          else begin e = q_exp_d.pop_front(); chk("d_rdata_sb", d_rdata, e); end
        end
        if (m_req && !p_mreq_obs) glog.push_back(m_addr[31:28] == 4'h2);
        p_mreq_obs = m_req;
      end
      p_rst = rst_n; p_i_req = i_req; p_d_req = d_req; p_d_we = d_we;
      p_i_addr = i_addr; p_d_addr = d_addr; p_d_wdata = d_wdata; p_d_be = d_be;
      p_m_ack = m_ack; p_m_rdata = m_rdata;
    end
  end

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while ((q_cmd_i.size() != 0 || q_cmd_d.size() != 0 || busy_i || busy_d) && n < max) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= max) begin
      n_mis++;
      $display("FAIL drain: requesters still busy after %0d cycles, required idle", n);
    end
    repeat (3) @(negedge clk);
    chk("i_sb_empty", 64'(q_exp_i.size()), 64'd0);
    chk("d_sb_empty", 64'(q_exp_d.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic cmd_t mk(input logic we, input logic [63:0] a, input logic [63:0] wd,
                              input logic [7:0] be, input logic tmo);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = wd; c.be = be; c.tmo = tmo;
    return c;
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_req", {63'd0, m_req}, 64'd0);
    chk("rst_i_ack", {63'd0, i_ack}, 64'd0);
    chk("rst_d_ack", {63'd0, d_ack}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_m_be", {56'd0, m_be}, 64'd0);
    chk("rst_i_rdata", i_rdata, 64'd0);
    rst_n = 1'b1;

    // Single fetch, memory answers 2 cycles into the grant
    resp_mode = 1;
    q_cmd_i.push_back(mk(1'b0, 64'h100, 64'h0, 8'h00, 1'b0));
    wait_drain(200);

    // Single store
    q_cmd_d.push_back(mk(1'b1, 64'h2000, 64'h55AA, 8'h0F, 1'b0));
    wait_drain(200);

    // Contention straight after reset: fetch first, then strict alternation
    pulse_reset();
    resp_mode = 0;
    glog.delete();
    for (int k = 0; k < 2; k++) begin
      q_cmd_i.push_back(mk(1'b0, {32'h0, 4'h1, 28'(k)}, 64'h0, 8'h00, 1'b0));
      q_cmd_d.push_back(mk(1'b0, {32'h0, 4'h2, 28'(k)}, 64'h0, 8'h00, 1'b0));
    end
    wait_drain(300);
    chk("alt_count", 64'(glog.size()), 64'd4);
    if (glog.size() == 4) begin
      chk("alt_0_fetch", {63'd0, glog[0]}, 64'd0);
      chk("alt_1_data",  {63'd0, glog[1]}, 64'd1);
      chk("alt_2_fetch", {63'd0, glog[2]}, 64'd0);
      chk("alt_3_data",  {63'd0, glog[3]}, 64'd1);
    end

    // Reset while a grant is outstanding
    resp_mode = 2;
    q_cmd_i.push_back(mk(1'b0, 64'h3000, 64'h0, 8'h00, 1'b0));
    n = 0;
    while (!m_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_grant_seen", {63'd0, m_req}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_m_req", {63'd0, m_req}, 64'd0);
    chk("mid_rst_i_ack", {63'd0, i_ack}, 64'd0);
    chk("mid_rst_d_ack", {63'd0, d_ack}, 64'd0);
    chk("mid_rst_err", {63'd0, err}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    resp_mode = 0;
    q_cmd_i.push_back(mk(1'b0, 64'h4000, 64'h0, 8'h00, 1'b0));
    wait_drain(200);

    // Randomized traffic with random delays, gaps and stray acks
    stray_en = 1;
    rand_gap = 1;
    for (int k = 0; k < 60; k++) begin
      q_cmd_i.push_back(mk(1'b0, {$urandom, 4'h1, 28'($urandom)}, 64'h0, 8'h00, 1'b0));
      q_cmd_d.push_back(mk(1'($urandom_range(0, 1)), {$urandom, 4'h2, 28'($urandom)},
                           {$urandom, $urandom}, 8'($urandom), 1'b0));
    end
    wait_drain(5000);
    stray_en = 0;
    rand_gap = 0;

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: watchdog aborts, err sticks
    resp_mode = 2;
    q_cmd_i.push_back(mk(1'b0, 64'h5000, 64'h0, 8'h00, 1'b1));
    wait_drain(200);
    chk("tmo_err_set", {63'd0, err}, 64'd1);
    resp_mode = 0;
    q_cmd_d.push_back(mk(1'b0, 64'h6000, 64'h0, 8'h00, 1'b0));
    wait_drain(200);
    chk("tmo_err_sticky", {63'd0, err}, 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
